// File: rtl/pdp1_cpu_div_ctrl_pkg.sv
// Shared types, widths and helpers for the PDP-1 DIV sequencer and its
// ones-complement magnitude helper.
package pdp1_cpu_div_ctrl_pkg;

  localparam int WORD_W            = 18;
  localparam int MAG_W             = 17;
  localparam int NUMER_W           = 2 * MAG_W;
  localparam int DIV_LATENCY_DEF   = 8;
  localparam int TIMEOUT_SLACK_DEF = 2;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [MAG_W-1:0]  mag_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } div_state_e;

  typedef struct packed {
    word_t ac;
    word_t io;
    logic  skip;
    logic  overflow;
    logic  error;
  } div_result_t;

  // Quotient only fits in 17 bits when the high dividend half is below the divisor.
  function automatic logic div_overflow(input mag_t dividend_hi, input mag_t divisor);
    return (dividend_hi >= divisor);
  endfunction

  // Failed DIV: AC/IO come back untouched, no skip.
  function automatic div_result_t fail_result(input word_t ac, input word_t io,
                                              input logic fault);
    div_result_t res;
    res.ac       = ac;
    res.io       = io;
    res.skip     = 1'b0;
    res.overflow = 1'b1;
    res.error    = fault;
    return res;
  endfunction

  function automatic div_result_t ok_result(input word_t ac, input word_t io);
    div_result_t res;
    res.ac       = ac;
    res.io       = io;
    res.skip     = 1'b1;
    res.overflow = 1'b0;
    res.error    = 1'b0;
    return res;
  endfunction

endpackage

// File: rtl/pdp1_cpu_div_ctrl_ones_mag.sv
// Conditional ones-complement inversion: yields the magnitude of a signed word
// (neg = its sign bit) or negates a magnitude (neg = result sign).
module pdp1_cpu_ones_mag
  import pdp1_cpu_div_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] val,
  input  logic              neg,
  output logic [WORD_W-1:0] res
);

  assign res = neg ? ~val : val;

endmodule

// File: rtl/pdp1_cpu_div_ctrl.sv
// DIV instruction sequencer: conditions ones-complement operands, screens
// divide overflow, drives one divider start, and restores result signs.
module pdp1_cpu_div_ctrl
  import pdp1_cpu_div_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY   = DIV_LATENCY_DEF,
  parameter int TIMEOUT_SLACK = TIMEOUT_SLACK_DEF
) (
  input  logic               in_clock,
  input  logic               in_reset,
  input  logic               i_start,
  input  logic [WORD_W-1:0]  i_ac,
  input  logic [WORD_W-1:0]  i_io,
  input  logic [WORD_W-1:0]  i_mb,
  output logic               o_busy,
  output logic               o_done,
  output logic [WORD_W-1:0]  o_ac,
  output logic [WORD_W-1:0]  o_io,
  output logic               o_skip,
  output logic               o_overflow,
  output logic               o_error,
  output logic               o_div_start,
  output logic [NUMER_W-1:0] o_div_numer,
  output logic [MAG_W-1:0]   o_div_denom,
  input  logic [NUMER_W-1:0] i_div_quotient,
  input  logic [MAG_W-1:0]   i_div_remain,
  input  logic               i_div_valid
);

  localparam int               CNT_W   = $clog2(DIV_LATENCY + TIMEOUT_SLACK + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(DIV_LATENCY);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_LATENCY + TIMEOUT_SLACK);

  div_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  word_t            ac_r;
  word_t            io_r;
  logic             sd_r;
  logic             qs_r;
  logic             ovf_r;

  word_t acm_s;
  word_t iom_s;
  word_t mbm_s;
  word_t quo_s;
  word_t rem_s;
  logic  ovf_s;
  logic  unused_bits_s;

  // IO shares the dividend sign with AC: the pair is one 36-bit number.
  pdp1_cpu_ones_mag u_ac_mag (.val(i_ac), .neg(i_ac[WORD_W-1]), .res(acm_s));
  pdp1_cpu_ones_mag u_io_mag (.val(i_io), .neg(i_ac[WORD_W-1]), .res(iom_s));
  pdp1_cpu_ones_mag u_mb_mag (.val(i_mb), .neg(i_mb[WORD_W-1]), .res(mbm_s));

  pdp1_cpu_ones_mag u_quo_mag (
    .val({1'b0, i_div_quotient[MAG_W-1:0]}),
    .neg(qs_r),
    .res(quo_s)
  );
  pdp1_cpu_ones_mag u_rem_mag (
    .val({1'b0, i_div_remain}),
    .neg(sd_r),
    .res(rem_s)
  );

  // Both zero encodings of the divisor give magnitude 0 and land here too.
  assign ovf_s = div_overflow(acm_s[MAG_W-1:0], mbm_s[MAG_W-1:0]);

  // Quotient high half is zero whenever the overflow screen passed.
  assign unused_bits_s = ^{i_div_quotient[NUMER_W-1:MAG_W], acm_s[WORD_W-1], mbm_s[WORD_W-1]};

  // Sequencer: accept, issue, wait for divider, publish result.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_r                                     <= ST_IDLE;
      cnt_r                                       <= '0;
      ac_r                                        <= '0;
      io_r                                        <= '0;
      sd_r                                        <= 1'b0;
      qs_r                                        <= 1'b0;
      ovf_r                                       <= 1'b0;
      o_busy                                      <= 1'b0;
      o_done                                      <= 1'b0;
      {o_ac, o_io, o_skip, o_overflow, o_error}   <= '0;
      o_div_start                                 <= 1'b0;
      o_div_numer                                 <= '0;
      o_div_denom                                 <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            ac_r        <= i_ac;
            io_r        <= i_io;
            sd_r        <= i_ac[WORD_W-1];
            qs_r        <= i_ac[WORD_W-1] ^ i_mb[WORD_W-1];
            ovf_r       <= ovf_s;
            o_div_numer <= {acm_s[MAG_W-1:0], iom_s[WORD_W-1:1]};
            o_div_denom <= mbm_s[MAG_W-1:0];
            o_div_start <= ~ovf_s;
            o_busy      <= 1'b1;
            state_r     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          o_div_start <= 1'b0;
          if (ovf_r) begin
            {o_ac, o_io, o_skip, o_overflow, o_error} <= fail_result(ac_r, io_r, 1'b0);
            o_done  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            cnt_r   <= CNT_ONE;
            state_r <= ST_WAIT;
          end
        end

        // Early valids are leftovers from a request cut short by reset.
        ST_WAIT: begin
          if (i_div_valid && (cnt_r >= CNT_LAT)) begin
            {o_ac, o_io, o_skip, o_overflow, o_error} <= ok_result(quo_s, rem_s);
            o_done  <= 1'b1;
            state_r <= ST_DONE;
          end else if (cnt_r == CNT_MAX) begin
            {o_ac, o_io, o_skip, o_overflow, o_error} <= fail_result(ac_r, io_r, 1'b1);
            o_done  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        ST_DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          cnt_r   <= '0;
          state_r <= ST_IDLE;
        end

        default: begin
          o_done      <= 1'b0;
          o_busy      <= 1'b0;
          o_div_start <= 1'b0;
          cnt_r       <= '0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdp1_cpu_div_ctrl.sv
// Self-checking bench for pdp1_cpu_div_ctrl: behavioural divider, arithmetic
// reference model, directed cases plus randomized operands.
module tb_pdp1_cpu_div_ctrl;

  logic        in_clock = 1'b0;
  logic        in_reset = 1'b1;
  logic        i_start  = 1'b0;
  logic [17:0] i_ac     = '0;
  logic [17:0] i_io     = '0;
  logic [17:0] i_mb     = '0;
  logic        o_busy, o_done, o_skip, o_overflow, o_error, o_div_start;
  logic [17:0] o_ac, o_io;
  logic [33:0] o_div_numer;
  logic [16:0] o_div_denom;
  logic [33:0] i_div_quotient;
  logic [16:0] i_div_remain;
  logic        i_div_valid;

  bit          div_en = 1'b1;
  bit          stray  = 1'b0;
  logic [7:0]  v_pipe = '0;
  logic [33:0] q_pipe [8];
  logic [16:0] r_pipe [8];

  int n_tests = 0;
  int n_fail  = 0;

  pdp1_cpu_div_ctrl dut (
    .in_clock(in_clock), .in_reset(in_reset), .i_start(i_start),
    .i_ac(i_ac), .i_io(i_io), .i_mb(i_mb),
    .o_busy(o_busy), .o_done(o_done), .o_ac(o_ac), .o_io(o_io),
    .o_skip(o_skip), .o_overflow(o_overflow), .o_error(o_error),
    .o_div_start(o_div_start), .o_div_numer(o_div_numer), .o_div_denom(o_div_denom),
    .i_div_quotient(i_div_quotient), .i_div_remain(i_div_remain), .i_div_valid(i_div_valid)
  );

  always #5 in_clock = ~in_clock;

  // Divider model: 8-stage pipe, never reset, so in-flight results survive a controller reset.
  always @(posedge in_clock) begin
    v_pipe    <= {v_pipe[6:0], o_div_start};
    q_pipe[0] <= (o_div_denom != 17'd0) ? o_div_numer / 34'(o_div_denom) : 34'd0;
    r_pipe[0] <= (o_div_denom != 17'd0) ? 17'(o_div_numer % 34'(o_div_denom)) : 17'd0;
    for (int k = 1; k < 8; k++) begin
      q_pipe[k] <= q_pipe[k-1];
      r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign i_div_valid    = (div_en & v_pipe[7]) | stray;
  assign i_div_quotient = stray ? 34'h0_0001_5555 : q_pipe[7];
  assign i_div_remain   = stray ? 17'h0AAAA : r_pipe[7];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clock);
    #1;
  endtask

  // Reference: signed ones-complement division done with plain integer arithmetic.
  function automatic void model(input logic [17:0] ac, input logic [17:0] io,
                                input logic [17:0] mb, input bit div_ok,
                                output logic [17:0] eac, output logic [17:0] eio,
                                output logic skip, output logic ovf, output logic err,
                                output int lat);
    longint unsigned a, i, m, dvd, q, r;
    bit sd, sm;
    sd = ac[17];
    sm = mb[17];
    a  = sd ? 64'h3FFFF - 64'(ac) : 64'(ac);
    i  = sd ? 64'h3FFFF - 64'(io) : 64'(io);
    m  = sm ? 64'h3FFFF - 64'(mb) : 64'(mb);
    if (a >= m) begin
      eac = ac; eio = io; skip = 1'b0; ovf = 1'b1; err = 1'b0; lat = 2;
    end else if (!div_ok) begin
      eac = ac; eio = io; skip = 1'b0; ovf = 1'b1; err = 1'b1; lat = 12;
    end else begin
      dvd  = a * 64'd131072 + i / 64'd2;
      q    = dvd / m;
      r    = dvd % m;
      eac  = (sd ^ sm) ? 18'(64'h3FFFF - q) : 18'(q);
      eio  = sd ? 18'(64'h3FFFF - r) : 18'(r);
      skip = 1'b1; ovf = 1'b0; err = 1'b0; lat = 10;
    end
  endfunction

  // One DIV request; stray_k > 0 injects a bogus valid in that cycle after accept.
  task automatic do_op(input logic [17:0] ac, input logic [17:0] io,
                       input logic [17:0] mb, input int stray_k);
    logic [17:0] eac, eio, gac, gio;
    logic es, eo, ee, gs, go, ge;
    int lat, done_k, starts, start_k;
    model(ac, io, mb, div_en, eac, eio, es, eo, ee, lat);
    tick();
    i_start = 1'b1; i_ac = ac; i_io = io; i_mb = mb;
    done_k = 0; starts = 0; start_k = 0;
    gac = '0; gio = '0; gs = 1'b0; go = 1'b0; ge = 1'b0;
    for (int k = 1; k <= 20 && done_k == 0; k++) begin
      tick();
      if (k == 1) chk("busy_after_accept", 64'(o_busy), 64'd1);
      if (o_div_start) begin starts++; start_k = k; end
      if (o_done) begin
        done_k = k;
        gac = o_ac; gio = o_io; gs = o_skip; go = o_overflow; ge = o_error;
      end
      i_start = (k <= lat) ? 1'($urandom) : 1'b0;
      i_ac    = 18'($urandom);
      i_io    = 18'($urandom);
      i_mb    = 18'($urandom);
      stray   = (k == stray_k);
    end
    stray = 1'b0;
    chk("done_latency", 64'(done_k), 64'(lat));
    chk("start_count", 64'(starts), (lat == 2) ? 64'd0 : 64'd1);
    if (starts == 1) chk("start_cycle", 64'(start_k), 64'd1);
    chk("ac", 64'(gac), 64'(eac));
    chk("io", 64'(gio), 64'(eio));
    chk("flags", 64'({gs, go, ge}), 64'({es, eo, ee}));
    tick();
    i_start = 1'b0;
    chk("done_one_cycle", 64'(o_done), 64'd0);
    chk("idle_after_done", 64'(o_busy), 64'd0);
    chk("ac_held", 64'(o_ac), 64'(eac));
  endtask

  task automatic reset_mid();
    tick();
    i_start = 1'b1; i_ac = 18'o0; i_io = 18'o100; i_mb = 18'o5;
    tick();
    i_start = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("rst_mid_no_done", 64'(o_done), 64'd0);
    end
    in_reset = 1'b1;
    tick();
    in_reset = 1'b0;
    chk("rst_mid_outputs", 64'({o_busy, o_done, o_skip, o_overflow, o_error, o_div_start}), 64'd0);
    chk("rst_mid_ac", 64'(o_ac), 64'd0);
    do_op(18'o0, 18'o1000, 18'o7, 0);
  endtask

  initial begin
    logic [16:0] am, mm, tmp;
    logic [17:0] ac, mb;
    repeat (3) tick();
    chk("reset_flags", 64'({o_busy, o_done, o_skip, o_overflow, o_error, o_div_start}), 64'd0);
    chk("reset_words", 64'({o_ac, o_io}), 64'd0);
    chk("reset_numer", 64'(o_div_numer), 64'd0);
    in_reset = 1'b0;

    do_op(18'o0, 18'o100, 18'o5, 3);
    do_op(18'o777777, 18'o777677, 18'o5, 0);
    do_op(18'o5, 18'o0, 18'o5, 1);
    do_op(18'o123, 18'o456, 18'o0, 0);
    do_op(18'o123, 18'o456, 18'o777777, 0);
    div_en = 1'b0;
    do_op(18'o1, 18'o2, 18'o700, 0);
    div_en = 1'b1;
    reset_mid();

    for (int n = 0; n < 40; n++) begin
      am = 17'($urandom);
      mm = 17'($urandom);
      if ($urandom_range(0, 3) != 0 && am > mm) begin
        tmp = am; am = mm; mm = tmp;
      end
      ac = $urandom_range(0, 1) != 0 ? ~{1'b0, am} : {1'b0, am};
      mb = $urandom_range(0, 1) != 0 ? ~{1'b0, mm} : {1'b0, mm};
      div_en = (n % 13) != 12;
      do_op(ac, 18'($urandom), mb, (n % 5 == 0) ? 4 : 0);
    end
    div_en = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
